// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers: ce prescaler to a 60 Hz tick, DT/ST down-counters,
// and a square-wave beep generator that runs while ST is non-zero.
module chip8_timers #(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20,
  parameter int TONE_DIV = 68182,
  parameter int TONE_W   = 17
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ce,
  input  logic       pause,
  input  logic       wr_dt,
  input  logic       wr_st,
  input  logic [7:0] wdata,
  output logic [7:0] dt,
  output logic [7:0] st,
  output logic       tick60,
  output logic       sound_on,
  output logic       beep
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_DIV - 1);

  logic [TICK_W-1:0] presc;
  logic [TONE_W-1:0] tone_cnt;

  assign sound_on = (st != 8'd0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      presc  <= '0;
      tick60 <= 1'b0;
    end else if (ce && !pause) begin
      if (presc == TICK_MAX) begin
        presc  <= '0;
        tick60 <= 1'b1;
      end else begin
        presc  <= presc + 1'b1;
        tick60 <= 1'b0;
      end
    end else begin
      tick60 <= 1'b0;
    end
  end

  // A write strobe beats a coincident tick; that tick is simply lost for that timer.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dt <= 8'd0;
    end else if (wr_dt) begin
      dt <= wdata;
    end else if (tick60 && (dt != 8'd0)) begin
      dt <= dt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      st <= 8'd0;
    end else if (wr_st) begin
      st <= wdata;
    end else if (tick60 && (st != 8'd0)) begin
      st <= st - 8'd1;
    end
  end

  // Clearing on silence/pause guarantees each restart begins low with a full half-period.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (!sound_on || pause) begin
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (ce) begin
      if (tone_cnt == TONE_MAX) begin
        tone_cnt <= '0;
        beep     <= ~beep;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_timers.sv
// Self-checking bench for chip8_timers: directed scenarios plus random traffic,
// checked every clk against a counting reference model.
module tb_chip8_timers;

  localparam int TD = 4;
  localparam int TN = 3;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       ce = 1'b1;
  logic       pause = 1'b0;
  logic       wr_dt = 1'b0;
  logic       wr_st = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] dt;
  logic [7:0] st;
  logic       tick60;
  logic       sound_on;
  logic       beep;

  int vectors = 0;
  int miscompares = 0;

  // reference model: ce count modulo TD, timer values, ce count of the current beep run
  int m_n, m_dt, m_st, m_run;
  bit m_tick;

  chip8_timers #(.TICK_DIV(TD), .TICK_W(3), .TONE_DIV(TN), .TONE_W(2)) dut (
    .clk(clk), .res(res), .ce(ce), .pause(pause), .wr_dt(wr_dt), .wr_st(wr_st),
    .wdata(wdata), .dt(dt), .st(st), .tick60(tick60), .sound_on(sound_on), .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_dt = 0; m_st = 0; m_run = 0; m_tick = 0;
  endtask

  task automatic check_all();
    chk("dt", {24'd0, dt}, m_dt);
    chk("st", {24'd0, st}, m_st);
    chk("tick60", {31'd0, tick60}, {31'd0, m_tick});
    chk("sound_on", {31'd0, sound_on}, (m_st != 0) ? 1 : 0);
    chk("beep", {31'd0, beep}, (m_run / TN) % 2);
  endtask

  task automatic step();
    bit old_tick;
    int old_st;
    @(posedge clk);
    if (res) begin
      model_reset();
    end else begin
      old_tick = m_tick;
      old_st = m_st;
      if (ce && !pause) begin
        m_n = (m_n + 1) % TD;
        m_tick = (m_n == 0);
      end else begin
        m_tick = 0;
      end
      if (wr_dt) m_dt = wdata;
      else if (old_tick && m_dt != 0) m_dt = m_dt - 1;
      if (wr_st) m_st = wdata;
      else if (old_tick && m_st != 0) m_st = m_st - 1;
      if (old_st == 0 || pause) m_run = 0;
      else if (ce) m_run = m_run + 1;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    res = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    res = 1'b0;
  endtask

  int ticks, gap, t0;
  bit found;

  initial begin
    #2;
    do_reset();

    // 1: free run, three ticks in 12 clks, no underflow
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick60) ticks++;
    end
    chk("ticks_in_12", ticks, 3);

    // 2: DT counts down 3..0 and holds
    wdata = 8'd3; wr_dt = 1'b1; step(); wr_dt = 1'b0;
    for (int i = 0; i < 24; i++) step();
    chk("dt_hold_zero", {24'd0, dt}, 0);

    // 3: ST write coincident with tick; DT still decrements
    wdata = 8'd9; wr_dt = 1'b1; step(); wr_dt = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_tick) found = 1; else step();
    end
    chk("tick_found_s3", found, 1);
    wdata = 8'd5; wr_st = 1'b1; step(); wr_st = 1'b0;
    chk("st_write_wins", {24'd0, st}, 5);

    // 4: beep runs while ST counts down, silent after
    wdata = 8'd2; wr_st = 1'b1; step(); wr_st = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("beep_silent", {31'd0, beep}, 0);

    // 5: pause freezes everything
    wdata = 8'd10; wr_dt = 1'b1; wr_st = 1'b1; step(); wr_dt = 1'b0; wr_st = 1'b0;
    pause = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick60) ticks++;
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_dt", {24'd0, dt}, 10);
    pause = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // 6: ce every 3rd clk -> tick spacing 12 clks; then mid-count reset
    found = 0; t0 = 0; gap = 0;
    for (int i = 0; i < 60; i++) begin
      ce = (i % 3 == 0);
      step();
      if (tick60) begin
        if (found && gap == 0) gap = i - t0;
        found = 1; t0 = i;
      end
    end
    chk("tick_spacing", gap, 12);
    ce = 1'b1;
    step(); step();
    do_reset();
    for (int i = 0; i < 6; i++) step();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      ce = ($urandom % 3) != 0;
      pause = ($urandom % 12) == 0;
      wr_dt = ($urandom % 20) == 0;
      wr_st = ($urandom % 15) == 0;
      wdata = 8'($urandom % 6);
      if (($urandom % 200) == 0) do_reset();
      else step();
    end
    wr_dt = 1'b0; wr_st = 1'b0; pause = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
